mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between two requesters: instruction fetch (IF) and data-cache refill/write-back (DC).
- Grants one requester at a time and sequences a fixed-latency access with a down-counter.
- Returns a one-cycle done pulse to the winner, plus stall levels for the pipeline's hazard logic.
- Sits between the pipeline/cache and the top-level memory pins.

Parameters:
- XLEN, 32, address/data width.
- MEM_LATENCY, 4, cycles per memory access, counted from the first access cycle to the done cycle inclusive; legal range 1..7.
- CNT_W, 3, latency counter width; must hold MEM_LATENCY-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_b  input  1  reset, asynchronous, active-high (port named as in the codebase; polarity and synchronicity fixed).
- if_req  input  1  fetch request; held high until if_done.
- if_addr  input  XLEN  fetch word address.
- if_done  output  1  one-cycle pulse; if_rdata valid this cycle.
- if_rdata  output  XLEN  fetch read data.
- if_stall  output  1  if_req & ~if_done.
- dc_req  input  1  cache request; held high until dc_done.
- dc_we  input  1  1 = write-back, 0 = refill read.
- dc_addr  input  XLEN  cache word address.
- dc_wdata  input  XLEN  write-back data.
- dc_done  output  1  one-cycle pulse; dc_rdata valid this cycle.
- dc_rdata  output  XLEN  refill read data.
- dc_stall  output  1  dc_req & ~dc_done.
- mem_addr  output  XLEN  memory address.
- mem_wdata  output  XLEN  memory write data.
- mem_rdata  input  XLEN  memory read data; combinational from mem_addr.
- mem_we  output  1  memory write strobe.
- busy  output  1  high in any non-IDLE state.

Behaviour:
- FSM states: IDLE, IF_ACC, DC_ACC.
  - Reset forces IDLE and cnt=0.
  - During reset: all outputs 0, and mem_addr/mem_wdata hold 0.
- IDLE transitions:
  - dc_req=1: go to DC_ACC. DC wins ties, because the older instruction is in the MEM stage.
  - Otherwise if_req=1: go to IF_ACC.
  - Otherwise stay in IDLE.
- On grant (IDLE exit edge):
  - Latch the winner's addr, we (IF always 0) and wdata into internal registers.
  - Load cnt = MEM_LATENCY-1.
  - Port inputs are not sampled again until the next IDLE.
- In IF_ACC/DC_ACC:
  - mem_addr and mem_wdata drive the latched values.
  - cnt decrements each cycle while nonzero.
  - The cycle with cnt==0 is the final cycle.
- Final cycle:
  - Winner's done=1.
  - rdata = mem_rdata (combinational pass-through).
  - mem_we = latched we, so exactly one write strobe per write access, on the last cycle.
  - Next state is IDLE.
- Latency:
  - Access cycles = MEM_LATENCY.
  - Request-to-done = MEM_LATENCY+1 cycles from the first cycle req is seen in IDLE.
  - MEM_LATENCY=1: done in the first access cycle.
- After done, the requester drops req on the following edge. A req still high in IDLE starts a new access, so back-to-back accesses are separated by exactly one IDLE cycle.
- Loser is held:
  - Its req stays high, its stall stays high, and its done=0.
  - It is granted at the next IDLE if the other requester is idle.
  - With fixed priority, continuous dc_req can starve IF; this is allowed when the optional feature is off.
- A req dropping mid-access does not abort: the access completes, done pulses and is ignored, and a write still commits.
- Address/data changes mid-access are ignored, since latched values are used.
- done, rdata and mem_we are 0 outside the final cycle; rdata is 0 when the matching done is 0.
- Reset mid-access:
  - Immediate return to IDLE.
  - mem_we and done drop asynchronously.
  - No write commits.
- busy = (state != IDLE).

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Add a last_grant flop, reset to IF.
  - On simultaneous requests in IDLE, grant the requester not granted last.
  - last_grant updates on every grant.
  - Single requests are granted as normal.
- Undefined: fixed DC priority exactly as in Behaviour; no extra flop.

Test Plan:
- Single fetch, MEM_LATENCY=4: if_req=1 with if_addr=0x0000_0040, mem_rdata=0x2402_0005 -> if_done one cycle on the 5th edge after req; if_rdata=0x2402_0005; mem_we never 1; busy for 4 cycles.
- Write-back: dc_req=1, dc_we=1, dc_addr=0x100, dc_wdata=0xDEAD_BEEF -> mem_addr=0x100 for 4 cycles; mem_we=1 only in the last cycle with mem_wdata=0xDEAD_BEEF; dc_done coincides with mem_we.
- Collision: if_req and dc_req rise together -> DC served first; if_stall high throughout; one IDLE cycle, then IF served; if_done 10 cycles after the requests.
- MEM_LATENCY=1 back-to-back: if_req held for two requests -> if_done pulses on alternate cycles; busy toggles 0,1,0,1.
- Reset mid-write: assert rst_b in the 2nd access cycle of a dc write -> mem_we never 1; all outputs 0; after release, a held dc_req restarts a full 4-cycle access.
- MEM_ARB_ROUND_ROBIN_EN defined, both reqs continuously high -> grants alternate DC, IF, DC, IF; without the macro, DC is granted every time.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates the single main-memory port between instruction fetch (IF)
//   and data-cache refill/write-back (DC). The winner's address, write
//   enable and write data are latched at grant. A down-counter then times
//   a fixed-latency access, and the requester gets a one-cycle done pulse.
//
//   Default arbitration: DC wins ties, because the older instruction sits
//   in MEM. With MEM_ARB_ROUND_ROBIN_EN defined, ties go to the requester
//   that was not granted last.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no access in flight; requests are sampled here only
//   IF_ACC | fetch access in flight; cnt counts down to the final cycle
//   DC_ACC | cache access in flight; cnt counts down to the final cycle
//
// Ports
//   clk                  clock, rising edge
//   rst_b                reset, asynchronous, ACTIVE-HIGH despite the name
//   if_req/if_addr       fetch request (held until if_done) and word address
//   if_done/if_rdata     one-cycle completion pulse and read data
//   if_stall             if_req & ~if_done
//   dc_req/dc_we         cache request (held until dc_done); 1 = write-back
//   dc_addr/dc_wdata     cache word address and write-back data
//   dc_done/dc_rdata     one-cycle completion pulse and refill data
//   dc_stall             dc_req & ~dc_done
//   mem_addr/mem_wdata   latched address/data of the access in flight
//   mem_rdata            memory read data, combinational from mem_addr
//   mem_we               write strobe, final access cycle only
//   busy                 high whenever an access is in flight
//
// Parameters
//   XLEN         address/data width
//   MEM_LATENCY  access length in cycles, first access cycle to done (1..7)
//   CNT_W        counter width; must hold MEM_LATENCY-1
//
// Build option
//   MEM_ARB_ROUND_ROBIN_EN  alternate grants on simultaneous requests

module mem_port_arbiter #(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 3
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_done,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_stall,
  input  logic            dc_req,
  input  logic            dc_we,
  input  logic [XLEN-1:0] dc_addr,
  input  logic [XLEN-1:0] dc_wdata,
  output logic            dc_done,
  output logic [XLEN-1:0] dc_rdata,
  output logic            dc_stall,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_we,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DC_ACC = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             SINGLE   = (MEM_LATENCY == 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   lat_addr;
  logic [XLEN-1:0]   lat_wdata;
  logic              lat_we;
  logic              if_done_q;
  logic              dc_done_q;
  logic              mem_we_q;
  logic              grant_dc;
  logic              grant_if;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = DC was granted most recently; reset value favours DC on the first tie
  logic last_grant_dc;

  always_comb begin
    grant_dc = 1'b0;
    grant_if = 1'b0;
    if (dc_req && if_req) begin
      grant_dc = ~last_grant_dc;
      grant_if = last_grant_dc;
    end else begin
      grant_dc = dc_req;
      grant_if = if_req;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      last_grant_dc <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_dc)
        last_grant_dc <= 1'b1;
      else if (grant_if)
        last_grant_dc <= 1'b0;
    end
  end
`else
  always_comb begin
    grant_dc = dc_req;
    grant_if = if_req & ~dc_req;
  end
`endif

  // The done/we flags are registered one cycle ahead of the final access
  // cycle: they are set on the edge where cnt steps 1 -> 0, or directly at
  // grant when the access is a single cycle long.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      if_done_q <= 1'b0;
      dc_done_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dc) begin
            state     <= DC_ACC;
            cnt       <= CNT_LOAD;
            lat_addr  <= dc_addr;
            lat_wdata <= dc_wdata;
            lat_we    <= dc_we;
            dc_done_q <= SINGLE;
            mem_we_q  <= SINGLE & dc_we;
          end else if (grant_if) begin
            state     <= IF_ACC;
            cnt       <= CNT_LOAD;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            if_done_q <= SINGLE;
          end
        end

        IF_ACC, DC_ACC: begin
          if (cnt == '0) begin
            state     <= IDLE;
            if_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              if_done_q <= (state == IF_ACC);
              dc_done_q <= (state == DC_ACC);
              mem_we_q  <= lat_we;
            end
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          if_done_q <= 1'b0;
          dc_done_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_done   = if_done_q;
  assign dc_done   = dc_done_q;
  assign mem_we    = mem_we_q;
  assign if_rdata  = if_done_q ? mem_rdata : '0;
  assign dc_rdata  = dc_done_q ? mem_rdata : '0;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign busy      = (state != IDLE);

  // Stall is gated by reset so every output reads 0 while reset is held.
  assign if_stall  = if_req & ~if_done_q & ~rst_b;
  assign dc_stall  = dc_req & ~dc_done_q & ~rst_b;

endmodule
